// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   SEG_HEX  : hex nibble -> active-high {g,f,e,d,c,b,a} pattern table
//   seg_on   : pin level that lights a segment/digit for a given polarity
//   seg_off  : pin level that darkens a segment/digit for a given polarity
//   seg_hex  : table lookup helper
package seg_pkg;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic seg_on(input bit active_low);
        return active_low ? 1'b0 : 1'b1;
    endfunction

    function automatic logic seg_off(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [6:0] seg_hex(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational digit decoder.
//   nibble : hex value to show
//   dp     : decimal point, 1 = lit
//   blank  : 1 = a-g dark (dp still follows dp)
//   seg    : active-high {dp,g,f,e,d,c,b,a}
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = {dp, (blank ? 7'h00 : seg_hex(nibble))};
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan driver with double-buffered image,
// decimal points, leading-zero blanking, PWM dimming and anti-ghost gaps.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : one-cycle strobe capturing data/dp/blank_lz/bright
//   data       : DIGITS hex nibbles, nibble i -> digit i (0 = least significant)
//   dp         : decimal point per digit, 1 = lit
//   blank_lz   : 1 = blank leading zero digits (digit 0 never blanked)
//   bright     : brightness code, duty = (bright+1)/2^BRIGHT_W
//   sel        : registered digit enables, one-hot when on
//   dig        : registered {dp,g,f,e,d,c,b,a}
//   frame_done : one-cycle pulse after the last slot of a frame
//
// Handshake: load has no ready; every cycle with load=1 is accepted. A load
// lands in the pending image and is promoted at the next frame boundary; a
// load on the boundary cycle itself goes straight to the active image.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int SCAN_CNT       = 50000,
    parameter bit ACTIVE_LOW_SEL = 1,
    parameter bit ACTIVE_LOW_SEG = 1,
    parameter int BRIGHT_W       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DIGITS*4-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            dig,
    output logic                  frame_done
);

    localparam int CNT_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{seg_off(ACTIVE_LOW_SEL)}};
    localparam logic [7:0]        DIG_OFF = {8{seg_off(ACTIVE_LOW_SEG)}};

    logic [CNT_W-1:0]    cnt_scan;
    logic [IDX_W-1:0]    idx;
    logic [BRIGHT_W-1:0] pwm;
    logic                tick;
    logic                boundary;

    logic                pend_valid;
    logic [DIGITS*4-1:0] pend_data;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_blz;
    logic [BRIGHT_W-1:0] pend_bright;

    logic [DIGITS*4-1:0] act_data;
    logic [DIGITS-1:0]   act_dp;
    logic                act_blz;
    logic [BRIGHT_W-1:0] act_bright;

    logic [DIGITS-1:0]   blank_vec;
    logic                zero_above;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [7:0]          seg_raw;
    logic [DIGITS-1:0]   onehot;
    logic                slot_en;

    logic [DIGITS-1:0]   sel_q;
    logic [7:0]          dig_q;
    logic                frame_done_q;

    assign tick     = (cnt_scan == CNT_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    // Prescaler, digit index and free-running PWM phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_scan <= '0;
            idx      <= '0;
            pwm      <= '0;
        end else begin
            pwm <= pwm + BRIGHT_W'(1);
            if (tick) begin
                cnt_scan <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt_scan <= cnt_scan + CNT_W'(1);
            end
        end
    end

    // Double buffer: the active image only changes on a frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_blz    <= 1'b0;
            pend_bright <= '1;
            act_data    <= '0;
            act_dp      <= '0;
            act_blz     <= 1'b0;
            act_bright  <= '1;
        end else if (boundary && load) begin
            act_data   <= data;
            act_dp     <= dp;
            act_blz    <= blank_lz;
            act_bright <= bright;
            pend_valid <= 1'b0;
        end else if (boundary && pend_valid) begin
            act_data   <= pend_data;
            act_dp     <= pend_dp;
            act_blz    <= pend_blz;
            act_bright <= pend_bright;
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_data   <= data;
            pend_dp     <= dp;
            pend_blz    <= blank_lz;
            pend_bright <= bright;
            pend_valid  <= 1'b1;
        end
    end

    // A digit is a leading zero when it and every higher nibble are zero.
    always_comb begin
        blank_vec  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above & (act_data[i*4 +: 4] == 4'h0);
            blank_vec[i] = act_blz & zero_above & (i > 0);
        end
    end

    // Compare-based select keeps idx values beyond DIGITS-1 out of range checks.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = act_data[i*4 +: 4];
                cur_dp    = act_dp[i];
                cur_blank = blank_vec[i];
            end
        end
    end

    seg_hex_decode u_decode (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .seg    (seg_raw)
    );

    // First cycle of every slot stays dark so the previous digit cannot ghost.
    always_comb begin
        onehot  = DIGITS'(1) << idx;
        slot_en = (cnt_scan != '0) && (pwm <= act_bright);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= SEL_OFF;
            dig_q        <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            sel_q        <= slot_en ? (ACTIVE_LOW_SEL ? ~onehot : onehot) : SEL_OFF;
            dig_q        <= ACTIVE_LOW_SEG ? ~seg_raw : seg_raw;
            frame_done_q <= boundary;
        end
    end

    assign sel        = sel_q;
    assign dig        = dig_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: DIGITS=6, SCAN_CNT=10, BRIGHT_W=3,
// active-low sel and segments. Each frame is checked cycle by cycle against
// a table of hand-decoded digit patterns.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 6;
    localparam int SCAN   = 10;
    localparam int FRAME  = DIGITS * SCAN;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [23:0] data;
    logic [5:0]  dp;
    logic        blank_lz;
    logic [2:0]  bright;
    logic [5:0]  sel;
    logic [7:0]  dig;
    logic        frame_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;

    logic [7:0] exp_q[$];

    typedef struct packed {
        logic [23:0] data;
        logic [5:0]  dp;
        logic        blz;
        logic [2:0]  bright;
        logic [47:0] exp_dig;  // {d5,d4,d3,d2,d1,d0}, active-low pin values
    } vec_t;

    vec_t vecs [9];
    localparam logic [47:0] ZERO_IMG = 48'hC0C0C0C0C0C0;

    seg_scan_ctrl #(
        .DIGITS(DIGITS), .SCAN_CNT(SCAN), .ACTIVE_LOW_SEL(1),
        .ACTIVE_LOW_SEG(1), .BRIGHT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .dp(dp),
        .blank_lz(blank_lz), .bright(bright), .sel(sel), .dig(dig),
        .frame_done(frame_done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Posedges since reset release: gives the expected slot position and PWM phase.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_vec(input int v);
        data     = vecs[v].data;
        dp       = vecs[v].dp;
        blank_lz = vecs[v].blz;
        bright   = vecs[v].bright;
        load     = 1'b1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    // Starts at a negedge where the scan is at slot 0 / count 0 (just after a
    // frame boundary or a reset release) and checks the next 60 sampled cycles.
    // Pins at the t-th negedge reflect scan position t-1. Up to two loads can
    // be issued during the frame at negedges ld1_t / ld2_t (-1 = none).
    task automatic check_frame(input logic [47:0] exp_dig, input logic [2:0] exp_br,
                               input int ld1_t, input int ld1_v,
                               input int ld2_t, input int ld2_v);
        int         s, j, d;
        bit         en;
        logic [5:0] exp_sel;
        for (int k = 0; k < DIGITS; k++) exp_q.push_back(exp_dig[k*8 +: 8]);
        for (int t = 1; t <= FRAME; t++) begin
            @(negedge clk);
            if (t == ld1_t)      drive_vec(ld1_v);
            else if (t == ld2_t) drive_vec(ld2_v);
            else                 load = 1'b0;
            s  = t - 1;
            j  = s % SCAN;
            d  = s / SCAN;
            en = (j != 0) && (((cyc - 1) % 8) <= int'(exp_br));
            exp_sel = en ? ~(6'd1 << d) : 6'h3F;
            cmp("sel", 32'(sel), 32'(exp_sel));
            if (en) cmp("dig", 32'(dig), 32'(exp_q[0]));
            cmp("frame_done", 32'(frame_done), (t == FRAME) ? 32'd1 : 32'd0);
            if (j == SCAN - 1) void'(exp_q.pop_front());
        end
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{data:24'h123456, dp:6'h00, blz:1'b0, bright:3'd7, exp_dig:48'hF9A4B0999282};
        vecs[1] = '{data:24'h000120, dp:6'h20, blz:1'b1, bright:3'd7, exp_dig:48'h7FFFFFF9A4C0};
        vecs[2] = '{data:24'hABCDEF, dp:6'h15, blz:1'b1, bright:3'd3, exp_dig:48'h8803C621860E};
        vecs[3] = '{data:24'h000000, dp:6'h00, blz:1'b1, bright:3'd0, exp_dig:48'hFFFFFFFFFFC0};
        vecs[4] = '{data:24'h000000, dp:6'h3F, blz:1'b0, bright:3'd7, exp_dig:48'h404040404040};
        vecs[5] = '{data:24'h789000, dp:6'h00, blz:1'b1, bright:3'd7, exp_dig:48'hF88090C0C0C0};
        vecs[6] = '{data:24'h050000, dp:6'h00, blz:1'b1, bright:3'd5, exp_dig:48'hFF92C0C0C0C0};
        vecs[7] = '{data:24'h111111, dp:6'h00, blz:1'b0, bright:3'd7, exp_dig:48'hF9F9F9F9F9F9};
        vecs[8] = '{data:24'h222222, dp:6'h00, blz:1'b0, bright:3'd7, exp_dig:48'hA4A4A4A4A4A4};

        rst = 1'b1; load = 1'b0; data = '0; dp = '0; blank_lz = 1'b0; bright = '0;

        // Reset state.
        @(negedge clk);
        cmp("rst_sel", 32'(sel), 32'h3F);
        cmp("rst_dig", 32'(dig), 32'hFF);
        cmp("rst_frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset image (zeros, full brightness); load vec0 mid-frame, which must not show yet.
        check_frame(ZERO_IMG, 3'd7, 20, 0, -1, -1);

        // Table: each frame shows vec i while vec i+1 is loaded for the next frame.
        // The last table frame receives two loads; only the second may ever appear.
        for (int i = 0; i < 7; i++) begin
            if (i < 6) check_frame(vecs[i].exp_dig, vecs[i].bright, 20, i + 1, -1, -1);
            else       check_frame(vecs[i].exp_dig, vecs[i].bright, 10, 7, 30, 8);
        end

        // 2s only; a load on the boundary cycle shows from the very next digit-0 slot.
        check_frame(vecs[8].exp_dig, 3'd7, FRAME - 1, 0, -1, -1);

        // Showing 123456: queue a pending load, then reset mid-slot.
        repeat (15) @(negedge clk);
        drive_vec(3);
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        // Scan position 24: digit 2, count 4 -> nibble 4.
        cmp("pre_rst_sel", 32'(sel), 32'h3B);
        cmp("pre_rst_dig", 32'(dig), 32'h99);
        #2 rst = 1'b1;
        #1;
        cmp("async_rst_sel", 32'(sel), 32'h3F);
        cmp("async_rst_dig", 32'(dig), 32'hFF);
        cmp("async_rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cleared image, and the discarded pending load never appears.
        check_frame(ZERO_IMG, 3'd7, -1, 0, -1, -1);
        check_frame(ZERO_IMG, 3'd7, -1, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
